// File: rtl/rps_pkg.sv
// Shared constants for the rock-paper-scissors score keeper: judge result bytes,
// FSM state encoding, decoded result codes and the best-of-N wins-needed table.
// No logic, no latency, no flow control.
package rps_pkg;

    localparam logic [7:0] RES_BYTE_TIE = 8'h00;
    localparam logic [7:0] RES_BYTE_P1  = 8'h31;
    localparam logic [7:0] RES_BYTE_P2  = 8'h32;
    localparam logic [7:0] RES_BYTE_INV = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_WON_P1 = 2'b10,
        ST_WON_P2 = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        RC_TIE = 2'b00,
        RC_P1  = 2'b01,
        RC_P2  = 2'b10,
        RC_INV = 2'b11
    } result_t;

    localparam logic [2:0] WINS_NEEDED_RST = 3'd1;

    // Length select 00/01/10/11 means best-of-1/3/5/7.
    function automatic logic [2:0] wins_needed(input logic [1:0] sel);
        logic [2:0] n;
        case (sel)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rps_result_decoder.sv
// Maps a judge result byte to a 2-bit result code; anything unrecognised is invalid.
// Purely combinational, zero latency.
// No flow control.
module rps_result_decoder
    import rps_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [1:0] code_o
);

    always_comb begin
        code_o = RC_INV;
        case (byte_i)
            RES_BYTE_TIE: code_o = RC_TIE;
            RES_BYTE_P1:  code_o = RC_P1;
            RES_BYTE_P2:  code_o = RC_P2;
            RES_BYTE_INV: code_o = RC_INV;
            default:      code_o = RC_INV;
        endcase
    end

endmodule

// File: rtl/rps_score_keeper.sv
// Match score keeper: counts round results from the judge up to a best-of-N win.
// Outputs registered, 1-cycle latency from a detected valid/start edge.
// No backpressure; ena=0 freezes every register including the edge detectors.
module rps_score_keeper
    import rps_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t     state_q, state_d;
    logic [2:0] p1_q, p1_d;
    logic [2:0] p2_q, p2_d;
    logic [2:0] need_q, need_d;
    logic [1:0] last_q, last_d;
    logic       err_q, err_d;
    logic       ack_q, ack_d;
    logic       valid_prev_q, start_prev_q;

    logic       valid_edge, start_edge;
    logic [1:0] code;
    logic       unused_hi;

    assign unused_hi  = ^uio_in[7:4];
    assign valid_edge = uio_in[0] & ~valid_prev_q;
    assign start_edge = uio_in[1] & ~start_prev_q;

    rps_result_decoder u_dec (
        .byte_i (ui_in),
        .code_o (code)
    );

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        need_d  = need_q;
        last_d  = last_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        // Start wins over a simultaneous result; that result is dropped.
        if (start_edge) begin
            state_d = ST_PLAY;
            p1_d    = 3'd0;
            p2_d    = 3'd0;
            err_d   = 1'b0;
            last_d  = RC_TIE;
            need_d  = wins_needed(uio_in[3:2]);
        end else if (valid_edge && (state_q == ST_PLAY)) begin
            ack_d  = 1'b1;
            last_d = code;
            case (code)
                RC_P1: begin
                    p1_d = p1_q + 3'd1;
                    if (p1_d == need_q) state_d = ST_WON_P1;
                end
                RC_P2: begin
                    p2_d = p2_q + 3'd1;
                    if (p2_d == need_q) state_d = ST_WON_P2;
                end
                RC_INV:  err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            p1_q         <= 3'd0;
            p2_q         <= 3'd0;
            need_q       <= WINS_NEEDED_RST;
            last_q       <= RC_TIE;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            valid_prev_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            need_q       <= need_d;
            last_q       <= last_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            valid_prev_q <= uio_in[0];
            start_prev_q <= uio_in[1];
        end
    end

    assign uo_out  = {state_q, p2_q, p1_q};
    assign uio_out = {last_q, err_q, ack_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: doc/rps_score_keeper.md
RPS_SCORE_KEEPER -- requirements
Module: rps_score_keeper

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge) and rst_n input 1 (0 = reset).
REQ-002 SHALL have ena, input, 1 bit: 0 freezes all state and holds all outputs.
REQ-003 SHALL have ui_in, input, 8 bits: result byte from the round judge (0x00 tie, 0x31 P1 win, 0x32 P2 win, 0x3F invalid).
REQ-004 SHALL have uio_in, input, 8 bits: [0] result_valid, [1] start, [3:2] length select (00/01/10/11 = best-of-1/3/5/7), [7:4] unused.
REQ-005 SHALL have uo_out, output, 8 bits: [2:0] P1 wins, [5:3] P2 wins, [7:6] match state.
REQ-006 SHALL have uio_out, output, 8 bits: [3:0] 0, [4] round_ack, [5] err, [7:6] last decoded result.
REQ-007 SHALL have uio_oe, output, 8 bits, constant 0xF0.

Function
REQ-010 SHALL detect a rising edge on result_valid and on start, each against its own registered previous value, so a held-high level counts exactly once.
REQ-011 SHALL use FSM states IDLE(00), PLAY(01), WON_P1(10), WON_P2(11), driven on uo_out[7:6].
REQ-012 On a start edge in any state, SHALL move to PLAY, clear both scores, err and last result, and latch wins_needed = 1/2/3/4 from uio_in[3:2].
REQ-013 In PLAY, on a valid edge, SHALL decode ui_in: 0x00 → tie, no score change; 0x31 → P1+1; 0x32 → P2+1; 0x3F or any other value → set err, no score change.
REQ-014 SHALL encode last result as 00 tie, 01 P1, 10 P2, 11 invalid/other, updated on every valid edge accepted in PLAY.
REQ-015 When an increment makes a score equal wins_needed, SHALL enter WON_P1 or WON_P2 in the same register update as the score change.
REQ-016 SHALL register all outputs; scores, state and last result reflect a valid edge on the clock edge after that edge is detected (1-cycle latency).
REQ-017 SHALL pulse round_ack high for exactly one cycle, coincident with the output update, for every valid edge accepted in PLAY, including tie and invalid.
REQ-018 SHALL ignore valid edges in IDLE, WON_P1 and WON_P2, with no ack and no change.
REQ-019 SHALL give start priority when start and valid edges occur in the same cycle: restart only, and discard the result.
REQ-020 SHALL keep err sticky until start or reset.
REQ-021 Scores are 3 bits, SHALL never exceed wins_needed, and SHALL never wrap.
REQ-022 SHALL ignore uio_in[3:2] changes except at a start edge.
REQ-023 While ena=0, edge-detect registers SHALL also hold, so an edge spanning an ena-low period is detected when ena returns high.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, scores=0, err=0, last result=00, round_ack=0, edge registers=0, wins_needed=1.
REQ-031 Reset mid-match SHALL abandon the match and produce uo_out=0x00 and uio_out=0x00 immediately.

Structure
REQ-040 Package rps_pkg SHALL hold the result byte constants (0x00, 0x31, 0x32, 0x3F), the FSM state encoding, the result-code encoding and the wins_needed table.
REQ-041 Combinational sub-module rps_result_decoder (byte → 2-bit code) SHALL be instantiated once.

Verification
REQ-050 Reset, start with sel=01, then valid edges with 0x31, 0x32, 0x31 → scores 1/0, 1/1, then 2/1 with uo_out[7:6]=10, and three acks.
REQ-051 In PLAY, valid with 0x3F, then 0x55 → err=1, last=11, scores unchanged; err stays 1 after a following 0x31 and clears on start.
REQ-052 valid held high 10 cycles with 0x32 → P2 increments once, with a single one-cycle ack.
REQ-053 Start and valid edges in the same cycle with 0x31 → scores 0/0, state PLAY, no ack.
REQ-054 sel=00, 0x00 then 0x32 → tie with ack and no score change, then WON_P2; further valid edges → no ack, outputs held.
REQ-055 Mid-match, assert rst_n=0 between clock edges → outputs 0 before the next clk; ena=0 during a valid edge → no change until ena=1.
